// File: rtl/tk1_bus_pkg.sv
// Shared bus header for the RAM arbiter slice.
//  - FSM state encoding used by ram_arbiter.
//  - Master IDs (bit positions in req/grant vectors).
//  - Default RAM address/data widths.
package tk1_bus_pkg;

  localparam int RAM_ADDR_W = 15;
  localparam int RAM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

endpackage

// File: rtl/arb_select.sv
// Combinational winner select for the two-master RAM arbiter.
//  req_i        : per-master request, bit index = master ID
//  last_grant_i : master ID that owned the previous access
//  winner_o     : one-hot winner, 0 when nobody requests
// Build option: RAM_ARB_ROUND_ROBIN_EN selects round robin on ties;
// when undefined, master 0 (CPU) always wins ties and last_grant_i is unused.
module arb_select
  import tk1_bus_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] winner_o
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  always_comb begin
    winner_o = req_i;
    // Tie: whoever did not own the last access goes next.
    if (&req_i) winner_o = (last_grant_i == M_DMA) ? 2'b01 : 2'b10;
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  always_comb begin
    winner_o = req_i;
    if (req_i[M_CPU]) winner_o = 2'b01;
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of the single-port application RAM.
// Master 0 is the CPU bus decoder, master 1 a DMA/copy engine.
// One access at a time: IDLE picks a winner and latches its request, BUSY
// drives the RAM until ram_ready (or a ready timeout), RESP returns a
// one-cycle ready plus read data to the owner.
// Ports:
//  clk, reset_n                 clock, synchronous active-low reset
//  mX_cs/we/address/write_data  master request (level, held until ready)
//  mX_read_data, mX_ready       response, read data valid with ready pulse
//  ram_*                        RAM side handshake
//  grant                        one-hot owner of current access, 0 in IDLE
//  timeout                      pulses with a ready forced by the timeout
// Build option: RAM_ARB_ROUND_ROBIN_EN (see arb_select).
module ram_arbiter
  import tk1_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = RAM_ADDR_W,
  parameter int DATA_WIDTH     = RAM_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    m0_cs,
  input  logic [DATA_WIDTH/8-1:0] m0_we,
  input  logic [ADDR_WIDTH-1:0]   m0_address,
  input  logic [DATA_WIDTH-1:0]   m0_write_data,
  output logic [DATA_WIDTH-1:0]   m0_read_data,
  output logic                    m0_ready,
  input  logic                    m1_cs,
  input  logic [DATA_WIDTH/8-1:0] m1_we,
  input  logic [ADDR_WIDTH-1:0]   m1_address,
  input  logic [DATA_WIDTH-1:0]   m1_write_data,
  output logic [DATA_WIDTH-1:0]   m1_read_data,
  output logic                    m1_ready,
  output logic                    ram_cs,
  output logic [DATA_WIDTH/8-1:0] ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_address,
  output logic [DATA_WIDTH-1:0]   ram_write_data,
  input  logic [DATA_WIDTH-1:0]   ram_read_data,
  input  logic                    ram_ready,
  output logic [1:0]              grant,
  output logic                    timeout
);

  localparam int WE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e            state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic                  last_q, last_d;
  logic [WE_W-1:0]       we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  tmo_q, tmo_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            winner;

  arb_select u_sel (
    .req_i        ({m1_cs, m0_cs}),
    .last_grant_i (last_q),
    .winner_o     (winner)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= M_DMA;  // master 0 first after reset
      we_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|winner) begin
          if (winner[M_DMA]) begin
            we_d    = m1_we;
            addr_d  = m1_address;
            wdata_d = m1_write_data;
          end else begin
            we_d    = m0_we;
            addr_d  = m0_address;
            wdata_d = m0_write_data;
          end
          grant_d = winner;
          cnt_d   = '0;
          tmo_d   = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // cnt_q = BUSY cycles already spent; this cycle is number cnt_q+1.
        if (ram_ready) begin
          rdata_d = ram_read_data;
          state_d = RESP;
        end else if (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          tmo_d   = 1'b1;
          state_d = RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        last_d  = grant_q[M_DMA] ? M_DMA : M_CPU;
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic busy, resp;
  assign busy = (state_q == BUSY);
  assign resp = (state_q == RESP);

  assign ram_cs         = busy;
  assign ram_we         = busy ? we_q    : '0;
  assign ram_address    = busy ? addr_q  : '0;
  assign ram_write_data = busy ? wdata_q : '0;

  assign m0_ready     = resp & grant_q[M_CPU];
  assign m1_ready     = resp & grant_q[M_DMA];
  assign m0_read_data = m0_ready ? rdata_q : '0;
  assign m1_read_data = m1_ready ? rdata_q : '0;
  assign timeout      = resp & tmo_q;
  assign grant        = grant_q;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          m_cs [2];
  logic [3:0]    m_we [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdata [2];
  bit            m_wait [2];
  logic [DW-1:0] m0_read_data, m1_read_data;
  logic          m0_ready, m1_ready;
  logic          ram_cs, ram_ready;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_write_data, ram_read_data;
  logic [1:0]    grant;
  logic          timeout;

  int checks = 0;
  int errors = 0;
  int order[$];

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_cs(m_cs[0]), .m0_we(m_we[0]), .m0_address(m_addr[0]), .m0_write_data(m_wdata[0]),
    .m0_read_data(m0_read_data), .m0_ready(m0_ready),
    .m1_cs(m_cs[1]), .m1_we(m_we[1]), .m1_address(m_addr[1]), .m1_write_data(m_wdata[1]),
    .m1_read_data(m1_read_data), .m1_ready(m1_ready),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_address(ram_address),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data), .ram_ready(ram_ready),
    .grant(grant), .timeout(timeout)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] we);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic rdy(input int m);
    return (m == 0) ? m0_ready : m1_ready;
  endfunction

  function automatic logic [31:0] rdat(input int m);
    return (m == 0) ? m0_read_data : m1_read_data;
  endfunction

  // RAM device model: ready after ram_lat waits (or randomly), or never when hung.
  logic [31:0] ram_mem [0:32767];
  int  ram_lat = 0;
  bit  ram_hang = 0;
  bit  rnd_lat = 0;
  int  wait_cnt = 0;
  bit  bk_we = 0;
  logic [AW-1:0] bk_addr = '0;
  logic [31:0]   bk_data = '0;

  initial ram_ready = 1'b0;
  initial ram_read_data = '0;

  always @(posedge clk) begin
    ram_ready <= 1'b0;
    if (bk_we) ram_mem[bk_addr] <= bk_data;
    if (!ram_cs) wait_cnt <= 0;
    else if (!ram_ready && !ram_hang) begin
      if (rnd_lat ? ($urandom_range(0, 2) == 0) : (wait_cnt >= ram_lat)) begin
        ram_ready     <= 1'b1;
        ram_read_data <= ram_mem[ram_address];
        if (ram_we != 4'h0) ram_mem[ram_address] <= merge(ram_mem[ram_address], ram_write_data, ram_we);
        wait_cnt <= 0;
      end else wait_cnt <= wait_cnt + 1;
    end
  end

  // Any ready to a master that is not waiting for one is spurious.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      if (rdy(i) && !m_wait[i]) begin
        errors++;
        $display("FAIL spurious_ready m%0d: got ready=1, expected 0 (no request pending)", i);
      end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    bk_addr = a; bk_data = d; bk_we = 1;
    @(negedge clk);
    bk_we = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    @(negedge clk); @(negedge clk);
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic run_req(input int m, input logic [3:0] we, input logic [AW-1:0] a,
                         input logic [31:0] d, output logic [31:0] rd, output logic tmo,
                         output bit ok, output int lat);
    ok = 0; rd = '0; tmo = 0; lat = 0;
    m_wait[m] = 1; m_we[m] = we; m_addr[m] = a; m_wdata[m] = d; m_cs[m] = 1;
    while (lat < 300) begin
      @(negedge clk);
      lat++;
      if (rdy(m)) begin
        ok = 1; rd = rdat(m); tmo = timeout;
        order.push_back(m);
        break;
      end
    end
    m_cs[m] = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ready_wait m%0d: no ready after %0d cycles, expected one", m, lat);
    end
    @(negedge clk);
    checks++;
    if (rdy(m) !== 1'b0) begin
      errors++;
      $display("FAIL single_ready m%0d: ready=%b in cycle after completion, expected 0", m, rdy(m));
    end
    m_wait[m] = 0;
  endtask

  task automatic test_reset();
    reset_n = 0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({ram_cs, ram_we, ram_address, ram_write_data, grant, timeout, m0_ready, m1_ready,
         m0_read_data, m1_read_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: cs=%b we=%h addr=%h grant=%b tmo=%b rdy=%b%b, expected all 0",
               ram_cs, ram_we, ram_address, grant, timeout, m1_ready, m0_ready);
    end
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic test_read();
    preload(15'h0010, 32'hDEADBEEF);
    ram_lat = 0;
    m_wait[0] = 1; m_we[0] = 4'h0; m_addr[0] = 15'h0010; m_wdata[0] = '0; m_cs[0] = 1;
    @(negedge clk);
    checks++;
    if (ram_cs !== 1'b1 || grant !== 2'b01 || ram_address !== 15'h0010 || ram_we !== 4'h0) begin
      errors++;
      $display("FAIL read_n1: cs=%b grant=%b addr=%h we=%h, expected 1 01 0010 0", ram_cs, grant, ram_address, ram_we);
    end
    @(negedge clk);
    checks++;
    if (m0_ready !== 1'b0) begin
      errors++; $display("FAIL read_n2: m0_ready=%b, expected 0", m0_ready);
    end
    @(negedge clk);
    checks++;
    if (m0_ready !== 1'b1 || m0_read_data !== 32'hDEADBEEF || m1_ready !== 1'b0 ||
        timeout !== 1'b0 || ram_cs !== 1'b0) begin
      errors++;
      $display("FAIL read_n3: rdy=%b data=%h m1_rdy=%b tmo=%b cs=%b, expected 1 DEADBEEF 0 0 0",
               m0_ready, m0_read_data, m1_ready, timeout, ram_cs);
    end
    m_cs[0] = 0;
    @(negedge clk);
    checks++;
    if (m0_ready !== 1'b0 || grant !== 2'b00) begin
      errors++; $display("FAIL read_n4: rdy=%b grant=%b, expected 0 00", m0_ready, grant);
    end
    m_wait[0] = 0;
  endtask

  task automatic test_write();
    preload(15'h7FFF, 32'hAAAAAAAA);
    ram_lat = 2;
    m_wait[1] = 1; m_we[1] = 4'b0011; m_addr[1] = 15'h7FFF; m_wdata[1] = 32'h12345678; m_cs[1] = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (ram_cs !== 1'b1 || ram_we !== 4'b0011 || ram_address !== 15'h7FFF ||
          ram_write_data !== 32'h12345678 || grant !== 2'b10) begin
        errors++;
        $display("FAIL write_busy%0d: cs=%b we=%b addr=%h data=%h grant=%b, expected 1 0011 7FFF 12345678 10",
                 k, ram_cs, ram_we, ram_address, ram_write_data, grant);
      end
      // Master inputs change while BUSY: must not reach the RAM.
      m_we[1] = 4'hF; m_addr[1] = 15'h0001; m_wdata[1] = 32'h0;
    end
    @(negedge clk);
    checks++;
    if (m1_ready !== 1'b1 || m0_ready !== 1'b0) begin
      errors++; $display("FAIL write_ready: m1_rdy=%b m0_rdy=%b, expected 1 0", m1_ready, m0_ready);
    end
    m_cs[1] = 0;
    @(negedge clk);
    m_wait[1] = 0;
    checks++;
    if (ram_mem[15'h7FFF] !== 32'hAAAA5678) begin
      errors++; $display("FAIL write_mem: mem=%h, expected AAAA5678", ram_mem[15'h7FFF]);
    end
    ram_lat = 0;
  endtask

  task automatic test_tie();
    logic [31:0] rd0, rd1; logic t0, t1; bit ok0, ok1; int l0, l1;
    int exp_order[4];
    do_reset();
    order.delete();
`ifdef RAM_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 1, 1};
`endif
    fork
      begin
        for (int i = 0; i < 2; i++) run_req(0, 4'h0, 15'(i), 32'h0, rd0, t0, ok0, l0);
      end
      begin
        for (int i = 0; i < 2; i++) run_req(1, 4'h0, 15'(i + 2), 32'h0, rd1, t1, ok1, l1);
      end
    join
    checks++;
    if (order.size() != 4) begin
      errors++; $display("FAIL tie_count: %0d completions, expected 4", order.size());
    end else
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (order[i] != exp_order[i]) begin
          errors++; $display("FAIL tie_order[%0d]: master %0d, expected %0d", i, order[i], exp_order[i]);
        end
      end
  endtask

  task automatic test_timeout();
    int cs_cycles = 0; int n = 0; bit seen = 0;
    ram_hang = 1;
    m_wait[0] = 1; m_we[0] = 4'h0; m_addr[0] = 15'h0010; m_cs[0] = 1;
    while (n < 100 && !seen) begin
      @(negedge clk);
      n++;
      if (ram_cs) cs_cycles++;
      if (m0_ready) begin
        seen = 1;
        checks++;
        if (m0_read_data !== 32'h0 || timeout !== 1'b1) begin
          errors++; $display("FAIL timeout_resp: data=%h tmo=%b, expected 0 1", m0_read_data, timeout);
        end
      end
    end
    m_cs[0] = 0;
    checks++;
    if (!seen || cs_cycles != TO) begin
      errors++; $display("FAIL timeout_busy: ready_seen=%0d busy_cycles=%0d, expected 1 %0d", seen, cs_cycles, TO);
    end
    @(negedge clk);
    checks++;
    if (timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse: tmo=%b after RESP, expected 0", timeout);
    end
    m_wait[0] = 0;
    ram_hang = 0;
  endtask

  task automatic test_reset_busy();
    int nrdy = 0;
    ram_hang = 1;
    m_wait[0] = 0;  // a ready for this aborted access would be spurious
    m_we[0] = 4'h0; m_addr[0] = 15'h0003; m_cs[0] = 1;
    repeat (4) @(negedge clk);
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    m_cs[0] = 0;
    checks++;
    if (ram_cs !== 1'b0 || grant !== 2'b00 || m0_ready !== 1'b0) begin
      errors++; $display("FAIL rst_busy: cs=%b grant=%b rdy=%b, expected 0 00 0", ram_cs, grant, m0_ready);
    end
    repeat (4) begin
      @(negedge clk);
      if (m0_ready || m1_ready) nrdy++;
    end
    checks++;
    if (nrdy != 0) begin
      errors++; $display("FAIL rst_noready: %0d ready pulses after reset, expected 0", nrdy);
    end
    ram_hang = 0;
    m_wait[0] = 1;
    m_we[0] = 4'h0; m_we[1] = 4'h0;
    m_cs[0] = 1; m_cs[1] = 1;
    @(negedge clk);
    checks++;
    if (grant !== 2'b01) begin
      errors++; $display("FAIL rst_tie: grant=%b, expected 01", grant);
    end
    m_cs[0] = 0; m_cs[1] = 0;
    nrdy = 0;
    repeat (4) begin
      @(negedge clk);
      if (m0_ready) nrdy++;
    end
    checks++;
    if (nrdy != 1) begin
      errors++; $display("FAIL rst_tie_ready: %0d m0 readies, expected 1", nrdy);
    end
    m_wait[0] = 0;
  endtask

  logic [31:0] ref_mem [0:7];

  task automatic rand_master(input int m, input int n);
    logic [31:0] rd, d; logic tmo; bit ok; int lat;
    logic [3:0] we; logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      we = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      a  = 15'($urandom_range(0, 7));
      d  = $urandom;
      run_req(m, we, a, d, rd, tmo, ok, lat);
      if (ok) begin
        checks++;
        if (tmo !== 1'b0) begin
          errors++; $display("FAIL rand_tmo m%0d: timeout=1, expected 0", m);
        end
        if (we == 4'h0) begin
          checks++;
          if (rd !== ref_mem[a[2:0]]) begin
            errors++; $display("FAIL rand_read m%0d addr %0d: got %h, expected %h", m, a, rd, ref_mem[a[2:0]]);
          end
        end else ref_mem[a[2:0]] = merge(ref_mem[a[2:0]], d, we);
      end
    end
  endtask

  task automatic test_random();
    int done0, done1;
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = $urandom;
      preload(15'(i), ref_mem[i]);
    end
    rnd_lat = 1;
    order.delete();
    fork
      rand_master(0, 25);
      rand_master(1, 25);
    join
    rnd_lat = 0;
    done0 = 0; done1 = 0;
    foreach (order[i]) if (order[i] == 0) done0++; else done1++;
    checks++;
    if (done0 != 25 || done1 != 25) begin
      errors++; $display("FAIL rand_count: m0=%0d m1=%0d completions, expected 25 25", done0, done1);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_cs[i] = 0; m_we[i] = '0; m_addr[i] = '0; m_wdata[i] = '0; m_wait[i] = 0;
    end
    @(negedge clk);
    test_reset();
    test_read();
    test_write();
    test_tie();
    test_timeout();
    test_reset_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
